// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the 1-to-3 memory-side request router.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bus_demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] TGT_RAM  = 2'd0;
    localparam logic [1:0] TGT_MMIO = 2'd1;
    localparam logic [1:0] TGT_ROM  = 2'd2;
    localparam logic [1:0] TGT_NONE = 2'd3;

    // TGT_NONE maps to no target at all, so a stray sel can never raise a valid.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            TGT_RAM:  sel_onehot = 3'b001;
            TGT_MMIO: sel_onehot = 3'b010;
            TGT_ROM:  sel_onehot = 3'b100;
            default:  sel_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/addr_decoder_3.sv
// Address decoder: maps a byte address onto one of three base/mask regions.
// Latency: purely combinational.
// Backpressure: none; region 0 wins over 1, which wins over 2, on overlap.
module addr_decoder_3 #(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] MASK0 = 32'hFFFF_0000,
    parameter logic [31:0] BASE1 = 32'h1000_0000,
    parameter logic [31:0] MASK1 = 32'hFFFF_F000,
    parameter logic [31:0] BASE2 = 32'h2000_0000,
    parameter logic [31:0] MASK2 = 32'hFFFF_0000
) (
    input  logic [31:0] i_addr,
    output logic        o_hit,
    output logic [1:0]  o_sel
);
    import bus_demux_pkg::*;

    // Priority match of the address against the three regions.
    always_comb begin
        o_hit = 1'b0;
        o_sel = TGT_NONE;
        if ((i_addr & MASK0) == BASE0) begin
            o_hit = 1'b1;
            o_sel = TGT_RAM;
        end else if ((i_addr & MASK1) == BASE1) begin
            o_hit = 1'b1;
            o_sel = TGT_MMIO;
        end else if ((i_addr & MASK2) == BASE2) begin
            o_hit = 1'b1;
            o_sel = TGT_ROM;
        end
    end

endmodule

// File: rtl/bus_demux_3_outputs.sv
// Registered 1-to-3 request router (RAM / MMIO / ROM), one transaction in flight.
// Latency: mapped zero-wait read = response valid 3 cycles after accept; unmapped = 1 cycle.
// Backpressure: in_ready only in IDLE; waits on tgt_ready, tgt_resp_valid and in_resp_ready.
// Optional watchdog on ISSUE/WAIT enabled by macro BUS_DEMUX_TIMEOUT_EN.
module bus_demux_3_outputs #(
    parameter logic [31:0] BASE0          = 32'h0000_0000,
    parameter logic [31:0] MASK0          = 32'hFFFF_0000,
    parameter logic [31:0] BASE1          = 32'h1000_0000,
    parameter logic [31:0] MASK1          = 32'hFFFF_F000,
    parameter logic [31:0] BASE2          = 32'h2000_0000,
    parameter logic [31:0] MASK2          = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_we,
    input  logic [3:0]  in_wstrb,
    output logic        in_resp_valid,
    input  logic        in_resp_ready,
    output logic [31:0] in_rdata,
    output logic        in_err,
    output logic [2:0]  tgt_valid,
    input  logic [2:0]  tgt_ready,
    output logic [31:0] tgt_addr,
    output logic [31:0] tgt_wdata,
    output logic        tgt_we,
    output logic [3:0]  tgt_wstrb,
    input  logic [2:0]  tgt_resp_valid,
    input  logic [95:0] tgt_rdata
);
    import bus_demux_pkg::*;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_hit;
    logic [1:0]  w_sel;
    logic [2:0]  w_sel_oh;
    logic        w_accept;
    logic        w_tgt_hs;
    logic        w_tgt_resp;
    logic        w_timeout;
    logic [31:0] w_sel_rdata;

    addr_decoder_3 #(
        .BASE0 (BASE0), .MASK0 (MASK0),
        .BASE1 (BASE1), .MASK1 (MASK1),
        .BASE2 (BASE2), .MASK2 (MASK2)
    ) u_dec (
        .i_addr (in_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    // Only the latched target's ready/response bits are ever looked at.
    assign w_sel_oh   = sel_onehot(r_sel);
    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_tgt_hs   = (r_state == ISSUE) && |(tgt_ready & w_sel_oh);
    assign w_tgt_resp = (r_state == WAIT) && |(tgt_resp_valid & w_sel_oh);

    // Read-data slice of the selected target.
    always_comb begin
        w_sel_rdata = 32'h0;
        case (r_sel)
            TGT_RAM:  w_sel_rdata = tgt_rdata[31:0];
            TGT_MMIO: w_sel_rdata = tgt_rdata[63:32];
            TGT_ROM:  w_sel_rdata = tgt_rdata[95:64];
            default:  w_sel_rdata = 32'h0;
        endcase
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] r_to_cnt;

    // Watchdog: zero in the first ISSUE cycle, counts every ISSUE/WAIT cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = ((r_state == ISSUE) || (r_state == WAIT)) &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; a real response beats a simultaneous watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_state_nxt = w_hit ? ISSUE : RESP;
            ISSUE: if (w_timeout) w_state_nxt = RESP;
                   else if (w_tgt_hs) w_state_nxt = WAIT;
            WAIT:  if (w_tgt_resp || w_timeout) w_state_nxt = RESP;
            RESP:  if (in_resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready      = (r_state == IDLE);
        in_resp_valid = (r_state == RESP);
        tgt_valid     = (r_state == ISSUE) ? w_sel_oh : 3'b000;
    end

    // Request payload and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel   <= TGT_NONE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_wstrb <= 4'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_sel   <= w_sel;
            r_addr  <= in_addr;
            r_wdata <= in_wdata;
            r_we    <= in_we;
            r_wstrb <= in_wstrb;
            r_rdata <= 32'h0;
            r_err   <= !w_hit;
        end else if (w_tgt_resp) begin
            r_rdata <= r_we ? 32'h0 : w_sel_rdata;
            r_err   <= 1'b0;
        end else if (w_timeout) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
        end else if ((r_state == RESP) && in_resp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end
    end

    assign tgt_addr  = r_addr;
    assign tgt_wdata = r_wdata;
    assign tgt_we    = r_we;
    assign tgt_wstrb = r_wstrb;
    assign in_rdata  = r_rdata;
    assign in_err    = r_err;

endmodule

// File: tb/tb_bus_demux_3_outputs.sv
// Directed bench for bus_demux_3_outputs with a response scoreboard.
// Latency: n/a.
// Backpressure: the bench drives tgt_ready and in_resp_ready stalls itself.
module tb_bus_demux_3_outputs;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_we;
    logic [3:0]  in_wstrb;
    logic        in_resp_valid;
    logic        in_resp_ready;
    logic [31:0] in_rdata;
    logic        in_err;
    logic [2:0]  tgt_valid;
    logic [2:0]  tgt_ready;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic        tgt_we;
    logic [3:0]  tgt_wstrb;
    logic [2:0]  tgt_resp_valid;
    logic [95:0] tgt_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    bus_demux_3_outputs #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_we          (in_we),
        .in_wstrb       (in_wstrb),
        .in_resp_valid  (in_resp_valid),
        .in_resp_ready  (in_resp_ready),
        .in_rdata       (in_rdata),
        .in_err         (in_err),
        .tgt_valid      (tgt_valid),
        .tgt_ready      (tgt_ready),
        .tgt_addr       (tgt_addr),
        .tgt_wdata      (tgt_wdata),
        .tgt_we         (tgt_we),
        .tgt_wstrb      (tgt_wstrb),
        .tgt_resp_valid (tgt_resp_valid),
        .tgt_rdata      (tgt_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted response is matched to the oldest expectation.
    always @(negedge clk) begin
        if (resetn && in_resp_valid && in_resp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got err=%b rdata=%h, no response expected", in_err, in_rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({in_err, in_rdata} !== e) begin
                    n_err++;
                    $display("FAIL resp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                             in_err, in_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    // One full transaction starting in an IDLE cycle; ends at the next IDLE cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                           input logic [3:0] wstrb, input int rdy_wait, input logic [31:0] tdata,
                           input logic spur, input int hold, input logic [2:0] oh,
                           input logic [31:0] exp_rd, input logic exp_err);
        int idx;
        idx = oh[1] ? 1 : (oh[2] ? 2 : 0);
        in_valid      = 1'b1;
        in_addr       = addr;
        in_wdata      = wdata;
        in_we         = we;
        in_wstrb      = wstrb;
        in_resp_ready = (hold == 0);
        @(negedge clk);
        chk("idle_accept", {in_ready, in_resp_valid, in_err, in_rdata, tgt_valid},
            {1'b1, 1'b0, 1'b0, 32'h0, 3'b000});
        exp_q.push_back({exp_err, exp_rd});
        tick();
        in_valid = 1'b0;
        in_addr  = 32'hFFFF_FFFF;
        in_wdata = 32'hFFFF_FFFF;
        in_we    = ~we;
        in_wstrb = ~wstrb;
        if (oh != 3'b000) begin
            for (int i = 0; i <= rdy_wait; i++) begin
                tgt_ready      = (i == rdy_wait) ? oh : ~oh;
                tgt_resp_valid = (i == rdy_wait) ? oh : ~oh;
                tgt_rdata      = {3{~tdata}};
                @(negedge clk);
                chk("issue_vld", {in_ready, in_resp_valid, tgt_valid}, {1'b0, 1'b0, oh});
                chk("issue_addr", tgt_addr, addr);
                chk("issue_wpay", {tgt_wdata, tgt_we, tgt_wstrb}, {wdata, we, wstrb});
                tick();
            end
            tgt_ready = 3'b000;
            if (spur) begin
                tgt_resp_valid = ~oh;
                tgt_rdata      = {3{~tdata}};
                @(negedge clk);
                chk("wait_spur", {tgt_valid, in_resp_valid}, {3'b000, 1'b0});
                tick();
            end
            tgt_resp_valid = oh;
            tgt_rdata      = {3{~tdata}};
            tgt_rdata[idx*32 +: 32] = tdata;
            @(negedge clk);
            chk("wait_vld", {tgt_valid, in_resp_valid}, {3'b000, 1'b0});
            tick();
            tgt_resp_valid = 3'b000;
        end
        for (int i = 0; i <= hold; i++) begin
            in_resp_ready = (i == hold);
            @(negedge clk);
            chk("resp_hold", {in_resp_valid, tgt_valid, in_ready, in_err, in_rdata},
                {1'b1, 3'b000, 1'b0, exp_err, exp_rd});
            tick();
        end
        in_resp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        resetn         = 1'b0;
        in_valid       = 1'b0;
        in_addr        = 32'h0;
        in_wdata       = 32'h0;
        in_we          = 1'b0;
        in_wstrb       = 4'h0;
        in_resp_ready  = 1'b1;
        tgt_ready      = 3'b000;
        tgt_resp_valid = 3'b000;
        tgt_rdata      = 96'h0;
        repeat (3) tick();
        chk("reset_outs", {in_ready, in_resp_valid, in_err, in_rdata, tgt_valid},
            {1'b1, 1'b0, 1'b0, 32'h0, 3'b000});
        chk("reset_pay", {tgt_addr, tgt_we, tgt_wstrb}, {32'h0, 1'b0, 4'h0});
        resetn = 1'b1;
        tick();

        // RAM read, zero-wait target
        run_txn(32'h0000_0040, 32'h0, 1'b0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0, 3'b001, 32'hDEAD_BEEF, 1'b0);
        // MMIO write, target stalls ready for 3 cycles; writes return zero data
        run_txn(32'h1000_0004, 32'h55, 1'b1, 4'b0001, 3, 32'h1234_5678, 1'b0, 0, 3'b010, 32'h0, 1'b0);
        // unmapped read
        run_txn(32'h3000_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 1'b0, 0, 3'b000, 32'h0, 1'b1);
        // ROM read with spurious responses and initiator stalled 5 cycles
        run_txn(32'h2000_0100, 32'h0, 1'b0, 4'hF, 1, 32'hCAFE_F00D, 1'b1, 5, 3'b100, 32'hCAFE_F00D, 1'b0);
        // back-to-back: last word of MMIO window
        run_txn(32'h1000_0FFC, 32'h0, 1'b0, 4'hF, 0, 32'hA5A5_0001, 1'b0, 0, 3'b010, 32'hA5A5_0001, 1'b0);
        // first word past MMIO window
        run_txn(32'h1000_1000, 32'h77, 1'b1, 4'hF, 0, 32'h0, 1'b0, 2, 3'b000, 32'h0, 1'b1);
        // last word of RAM window
        run_txn(32'h0000_FFFC, 32'h0, 1'b0, 4'hF, 2, 32'h0BAD_CAFE, 1'b0, 1, 3'b001, 32'h0BAD_CAFE, 1'b0);
        // first word past RAM window
        run_txn(32'h0001_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 1'b0, 0, 3'b000, 32'h0, 1'b1);

`ifdef BUS_DEMUX_TIMEOUT_EN
        in_valid = 1'b1;
        in_addr  = 32'h1000_0010;
        in_we    = 1'b0;
        @(negedge clk);
        chk("to_accept", in_ready, 1'b1);
        exp_q.push_back({1'b1, 32'h0});
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_issue", tgt_valid, 3'b010);
            tick();
        end
        @(negedge clk);
        chk("to_resp", {in_resp_valid, tgt_valid, in_err}, {1'b1, 3'b000, 1'b1});
        tick();
        tgt_resp_valid = 3'b010;
        tgt_rdata      = {3{32'hFFFF_FFFF}};
        @(negedge clk);
        chk("to_stale", {in_resp_valid, in_ready}, {1'b0, 1'b1});
        tick();
        tgt_resp_valid = 3'b000;
`endif

        // reset while WAITing on the RAM
        in_valid = 1'b1;
        in_addr  = 32'h0000_0100;
        in_wdata = 32'h0000_00AA;
        in_we    = 1'b0;
        in_wstrb = 4'hF;
        tick();
        in_valid  = 1'b0;
        tgt_ready = 3'b001;
        @(negedge clk);
        chk("rst_issue", tgt_valid, 3'b001);
        tick();
        tgt_ready = 3'b000;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_outs", {in_resp_valid, in_err, in_rdata, tgt_valid}, {1'b0, 1'b0, 32'h0, 3'b000});
        chk("rst_pay", {tgt_addr, tgt_wdata[7:0], tgt_we, tgt_wstrb}, {32'h0, 8'h0, 1'b0, 4'h0});
        tick();
        resetn         = 1'b1;
        tgt_resp_valid = 3'b001;
        tgt_rdata      = {3{32'h1357_9BDF}};
        @(negedge clk);
        chk("rst_release", {in_ready, in_resp_valid, tgt_valid}, {1'b1, 1'b0, 3'b000});
        tick();
        tgt_resp_valid = 3'b000;
        @(negedge clk);
        chk("rst_stale", {in_ready, in_resp_valid, in_err, in_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
